alu_issue_stage: RTL and testbench

//  Registered issue stage that drives the ALU from the other side of its op/operand interface.

---
 rtl/alu_pkg.sv | 58 +++++
 rtl/rv_skid_buffer.sv | 88 ++++++++
 rtl/alu_issue_stage.sv | 181 ++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path.
//  - ALU op codes (4 bits) presented to the ALU
//  - RV32I major opcodes handled by the issue decoder
//  - funct7 values distinguishing base/alternate encodings
//  - issue_t: registered payload {illegal, alu_op, alu_a, alu_b}
package alu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned OPC_W  = 7;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned F7_W   = 7;

    localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [OP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [OP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'd5;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'd8;
    localparam logic [OP_W-1:0] ALU_SLTU = 4'd9;

    localparam logic [OPC_W-1:0] OPC_OP    = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OPIMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LUI   = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC = 7'b0010111;

    localparam logic [F7_W-1:0] F7_BASE = 7'h00;
    localparam logic [F7_W-1:0] F7_ALT  = 7'h20;

    typedef struct packed {
        logic              illegal;
        logic [OP_W-1:0]   alu_op;
        logic [XLEN-1:0]   alu_a;
        logic [XLEN-1:0]   alu_b;
    } issue_t;

    localparam int unsigned ISSUE_W = $bits(issue_t);

    // funct3 -> ALU op for the encodings that need no funct7 disambiguation
    function automatic logic [OP_W-1:0] f3_to_op(input logic [F3_W-1:0] f3);
        logic [OP_W-1:0] op;
        op = ALU_ADD;
        case (f3)
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
//  Ports: clk, rst_n (async active-low), flush,
//         in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data (downstream).
//  in_ready and out_valid are individual state flop bits; order is preserved.
module rv_skid_buffer #(
    parameter int unsigned W = 69
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // bit0 = output slot occupied, bit1 = skid slot occupied
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   main_q, main_d;
    logic [W-1:0]   skid_q, skid_d;
    logic           accept;
    logic           drain;

    assign in_ready  = ~state_q[1];
    assign out_valid = state_q[0];
    assign out_data  = main_q;

    assign accept = in_valid & ~state_q[1];
    assign drain  = state_q[0] & out_ready;

    // State and payload registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next state; flush overrides everything and drops any input
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = ST_FULL;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered issue stage: decodes RV32I OP/OP-IMM/LUI/AUIPC into {alu_op, alu_a, alu_b}
// and holds the result behind a valid/ready handshake.
//  Ports: clk, rst_n (async active-low), flush (sync drop-all),
//         in_valid/in_ready with instr, pc, rs1_data, rs2_data,
//         out_valid/out_ready with alu_op, alu_a, alu_b, illegal.
//  SKID_EN=1: 2-entry skid, in_ready from a flop. SKID_EN=0: single register,
//  in_ready = ~out_valid | out_ready.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter bit SKID_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  instr,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OP_W-1:0]  alu_op,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic             illegal
);

    logic [OPC_W-1:0] opcode;
    logic [F3_W-1:0]  f3;
    logic [F7_W-1:0]  f7;
    logic [XLEN-1:0]  imm_i;
    logic [XLEN-1:0]  imm_u;
    logic [XLEN-1:0]  shamt;
    logic             legal;
    issue_t           dec;
    issue_t           held;
    logic             unused_rd;

    assign opcode    = instr[6:0];
    assign f3        = instr[14:12];
    assign f7        = instr[31:25];
    assign imm_i     = {{20{instr[31]}}, instr[31:20]};
    assign imm_u     = {instr[31:12], 12'b0};
    assign shamt     = {27'b0, instr[24:20]};
    assign unused_rd = ^instr[11:7];

    // Instruction decode; any illegal encoding yields a zeroed payload with illegal set
    always_comb begin
        dec   = '0;
        legal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.alu_a = rs1_data;
                dec.alu_b = rs2_data;
                case (f3)
                    3'b000: begin
                        if (f7 == F7_BASE) begin
                            dec.alu_op = ALU_ADD;
                            legal      = 1'b1;
                        end else if (f7 == F7_ALT) begin
                            dec.alu_op = ALU_SUB;
                            legal      = 1'b1;
                        end
                    end
                    3'b101: begin
                        if (f7 == F7_BASE) begin
                            dec.alu_op = ALU_SRL;
                            legal      = 1'b1;
                        end else if (f7 == F7_ALT) begin
                            dec.alu_op = ALU_SRA;
                            legal      = 1'b1;
                        end
                    end
                    default: begin
                        if (f7 == F7_BASE) begin
                            dec.alu_op = f3_to_op(f3);
                            legal      = 1'b1;
                        end
                    end
                endcase
            end
            OPC_OPIMM: begin
                dec.alu_a = rs1_data;
                dec.alu_b = imm_i;
                case (f3)
                    3'b001: begin
                        dec.alu_b = shamt;
                        if (f7 == F7_BASE) begin
                            dec.alu_op = ALU_SLL;
                            legal      = 1'b1;
                        end
                    end
                    3'b101: begin
                        dec.alu_b = shamt;
                        if (f7 == F7_BASE) begin
                            dec.alu_op = ALU_SRL;
                            legal      = 1'b1;
                        end else if (f7 == F7_ALT) begin
                            dec.alu_op = ALU_SRA;
                            legal      = 1'b1;
                        end
                    end
                    default: begin
                        // imm[11:5] is part of the immediate here, not a funct7
                        dec.alu_op = f3_to_op(f3);
                        legal      = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                dec.alu_a  = '0;
                dec.alu_b  = imm_u;
                dec.alu_op = ALU_ADD;
                legal      = 1'b1;
            end
            OPC_AUIPC: begin
                dec.alu_a  = pc;
                dec.alu_b  = imm_u;
                dec.alu_op = ALU_ADD;
                legal      = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    generate
        if (SKID_EN) begin : g_skid
            logic [ISSUE_W-1:0] held_bits;

            rv_skid_buffer #(
                .W (ISSUE_W)
            ) u_skid (
                .clk       (clk),
                .rst_n     (rst_n),
                .flush     (flush),
                .in_valid  (in_valid),
                .in_ready  (in_ready),
                .in_data   (ISSUE_W'(dec)),
                .out_valid (out_valid),
                .out_ready (out_ready),
                .out_data  (held_bits)
            );

            assign held = issue_t'(held_bits);
        end else begin : g_single
            logic   valid_q;
            issue_t data_q;

            assign in_ready  = ~valid_q | out_ready;
            assign out_valid = valid_q;
            assign held      = data_q;

            // Single pipeline register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else if (in_ready) begin
                    valid_q <= in_valid;
                    if (in_valid) begin
                        data_q <= dec;
                    end
                end
            end
        end
    endgenerate

    assign alu_op  = held.alu_op;
    assign alu_a   = held.alu_a;
    assign alu_b   = held.alu_b;
    assign illegal = held.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode table streamed at full rate,
// then backpressure, flush and asynchronous reset sequences.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        illegal;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  exp_op;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_ill;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    alu_issue_stage #(
        .SKID_EN (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        instr    = i;
        pc       = p;
        rs1_data = a;
        rs2_data = b;
    endtask

    // Expect an ADD entry with the given operands at the output
    task automatic chk_add(input string nm, input logic [31:0] a, input logic [31:0] b);
        chk({nm, " valid"}, 32'(out_valid), 32'd1);
        chk({nm, " op"},    32'(alu_op),    32'd0);
        chk({nm, " a"},     alu_a,          a);
        chk({nm, " b"},     alu_b,          b);
    endtask

    task automatic fill_two();
        out_ready = 1'b0;
        @(negedge clk);
        drive(1'b1, 32'h0020_8033, 32'h0, 32'd1, 32'd2);
        @(negedge clk);
        drive(1'b1, 32'h0020_8033, 32'h0, 32'd3, 32'd4);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);

        //                instr          pc          rs1          rs2          op     a            b            ill
        vecs[0]  = '{32'h4020_8033, 32'h0,     32'd5,       32'd7,       4'd1, 32'd5,       32'd7,       1'b0}; // sub
        vecs[1]  = '{32'h0020_8033, 32'h0,     32'd10,      32'd20,      4'd0, 32'd10,      32'd20,      1'b0}; // add
        vecs[2]  = '{32'hFFF0_A013, 32'h0,     32'd3,       32'd0,       4'd8, 32'd3,       32'hFFFF_FFFF, 1'b0}; // slti -1
        vecs[3]  = '{32'h4030_D013, 32'h0,     32'h8000_0000, 32'd0,     4'd7, 32'h8000_0000, 32'd3,     1'b0}; // srai 3
        vecs[4]  = '{32'h0220_8033, 32'h0,     32'd5,       32'd7,       4'd0, 32'd0,       32'd0,       1'b1}; // mul
        vecs[5]  = '{32'h1234_5037, 32'h0,     32'd99,      32'd0,       4'd0, 32'd0,       32'h1234_5000, 1'b0}; // lui
        vecs[6]  = '{32'h1234_5017, 32'h100,   32'd99,      32'd0,       4'd0, 32'h100,     32'h1234_5000, 1'b0}; // auipc
        vecs[7]  = '{32'h0030_9093, 32'h0,     32'hF,       32'd0,       4'd5, 32'hF,       32'd3,       1'b0}; // slli 3
        vecs[8]  = '{32'h4030_9093, 32'h0,     32'hF,       32'd0,       4'd0, 32'd0,       32'd0,       1'b1}; // slli bad f7
        vecs[9]  = '{32'h0020_C033, 32'h0,     32'hF0,      32'h0F,      4'd4, 32'hF0,      32'h0F,      1'b0}; // xor
        vecs[10] = '{32'h8000_F013, 32'h0,     32'd1,       32'd0,       4'd2, 32'd1,       32'hFFFF_F800, 1'b0}; // andi -2048
        vecs[11] = '{32'h0020_8063, 32'h0,     32'd1,       32'd2,       4'd0, 32'd0,       32'd0,       1'b1}; // beq
        vecs[12] = '{32'h4020_D033, 32'h0,     32'hAA,      32'd4,       4'd7, 32'hAA,      32'd4,       1'b0}; // sra
        vecs[13] = '{32'h0020_B033, 32'h0,     32'd6,       32'd8,       4'd9, 32'd6,       32'd8,       1'b0}; // sltu

        repeat (2) @(negedge clk);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready",  32'(in_ready),  32'd1);
        chk("rst alu_op",    32'(alu_op),    32'd0);
        chk("rst alu_a",     alu_a,          32'd0);
        chk("rst alu_b",     alu_b,          32'd0);
        chk("rst illegal",   32'(illegal),   32'd0);
        rst_n = 1'b1;

        // Decode table streamed back to back: entry i appears one cycle after it is driven
        for (int i = 0; i <= NV; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("v%0d valid", i - 1), 32'(out_valid), 32'd1);
                chk($sformatf("v%0d op", i - 1),    32'(alu_op),    32'(vecs[i-1].exp_op));
                chk($sformatf("v%0d a", i - 1),     alu_a,          vecs[i-1].exp_a);
                chk($sformatf("v%0d b", i - 1),     alu_b,          vecs[i-1].exp_b);
                chk($sformatf("v%0d ill", i - 1),   32'(illegal),   32'(vecs[i-1].exp_ill));
                chk($sformatf("v%0d in_ready", i - 1), 32'(in_ready), 32'd1);
            end
            if (i < NV)
                drive(1'b1, vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
            else
                drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        end
        @(negedge clk);
        chk("drain out_valid", 32'(out_valid), 32'd0);

        // Backpressure: two entries fill output + skid, then drain in order
        out_ready = 1'b0;
        @(negedge clk);
        drive(1'b1, 32'h0020_8033, 32'h0, 32'd1, 32'd2);
        @(negedge clk);
        chk("bp1 in_ready", 32'(in_ready), 32'd1);
        chk_add("bp1 A", 32'd1, 32'd2);
        drive(1'b1, 32'h0020_8033, 32'h0, 32'd3, 32'd4);
        @(negedge clk);
        chk("bp2 in_ready", 32'(in_ready), 32'd0);
        chk_add("bp2 A held", 32'd1, 32'd2);
        drive(1'b1, 32'h0020_8033, 32'h0, 32'd77, 32'd77); // not accepted while full
        @(negedge clk);
        chk("bp3 in_ready", 32'(in_ready), 32'd0);
        chk_add("bp3 A held", 32'd1, 32'd2);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        out_ready = 1'b1;
        @(negedge clk);
        chk_add("bp4 B", 32'd3, 32'd4);
        chk("bp4 in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("bp5 empty", 32'(out_valid), 32'd0);

        // Flush with skid full and a live input: everything dropped
        fill_two();
        chk("fl pre in_ready", 32'(in_ready), 32'd0);
        flush = 1'b1;
        drive(1'b1, 32'h0020_8033, 32'h0, 32'd9, 32'd9);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("fl out_valid", 32'(out_valid), 32'd0);
        chk("fl in_ready",  32'(in_ready),  32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("fl stale%0d", k), 32'(out_valid), 32'd0);
        end
        drive(1'b1, 32'h0020_8033, 32'h0, 32'd11, 32'd12);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk_add("fl post", 32'd11, 32'd12);

        // Asynchronous reset mid-cycle with skid full
        fill_two();
        chk("ar pre valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar out_valid", 32'(out_valid), 32'd0);
        chk("ar in_ready",  32'(in_ready),  32'd1);
        chk("ar alu_op",    32'(alu_op),    32'd0);
        chk("ar alu_a",     alu_a,          32'd0);
        chk("ar alu_b",     alu_b,          32'd0);
        chk("ar illegal",   32'(illegal),   32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("ar after valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
